// File: rtl/heap_array_alloc_arbiter.sv
// heap_array_alloc_arbiter
// Round-robin front end for the heap array allocator shared by NReq
// requesters. Allocations reuse the most recently freed array (LIFO stack)
// or take the next fresh index. Each allocated array gets its NArea heap
// words zeroed and its arraySizes entry cleared before the requester sees
// its grant. Frees push the index back onto the stack.

module heap_array_alloc_arbiter #(
    parameter int NReq               = 4,
    parameter int NArrays            = 16,
    parameter int NArea              = 4,
    parameter int MemoryElementWidth = 12
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req_valid,
    input  logic [NReq-1:0]                    req_free,
    input  logic [NReq*MemoryElementWidth-1:0] req_array,
    output logic [NReq-1:0]                    grant,
    output logic [MemoryElementWidth-1:0]      resp_array,
    output logic                               resp_error,
    output logic                               heap_we,
    output logic [MemoryElementWidth-1:0]      heap_addr,
    output logic [MemoryElementWidth-1:0]      heap_wdata,
    output logic                               size_we,
    output logic [MemoryElementWidth-1:0]      size_array,
    output logic [MemoryElementWidth-1:0]      in_use,
    output logic [MemoryElementWidth-1:0]      high_water
);

    localparam int W  = MemoryElementWidth;
    localparam int CW = $clog2(NArrays + 1);
    localparam int SW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int RW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int KW = (NArea > 1) ? $clog2(NArea) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    // Arbitration
    logic [RW-1:0]  rr;
    logic [RW-1:0]  win;
    logic [RW-1:0]  pick;
    logic [RW-1:0]  cand;
    logic           found;
    logic           accept;

    // Latched transaction
    logic [W-1:0]   cur_index;
    logic           cur_error;
    logic [KW-1:0]  k;

    // Allocator bookkeeping
    logic [CW-1:0]  allocs;
    logic [CW-1:0]  freed_top;
    logic [CW-1:0]  allocs_next;
    logic [CW-1:0]  freed_top_next;
    logic [CW-1:0]  top_m1;
    logic [W-1:0]   freed [NArrays];

    // Decision for the request being accepted this cycle
    logic           sel_free;
    logic [W-1:0]   sel_array;
    logic [W-1:0]   dec_index;
    logic           dec_error;
    logic           dec_clear;
    logic           dec_push;
    logic [W-1:0]   use_next;

    // Round-robin search starting at rr, wrapping modulo NReq
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NReq; i++) begin
            cand = RW'((int'(rr) + i) % NReq);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign sel_free  = req_free[pick];
    assign sel_array = req_array[int'(pick)*W +: W];

    // Work out what the winning request would do to the stack and counters
    always_comb begin
        top_m1         = freed_top - 1'b1;
        dec_index      = '0;
        dec_error      = 1'b0;
        dec_clear      = 1'b0;
        dec_push       = 1'b0;
        allocs_next    = allocs;
        freed_top_next = freed_top;
        if (!sel_free) begin
            if (freed_top != '0) begin
                dec_index      = freed[SW'(top_m1)];
                freed_top_next = top_m1;
                dec_clear      = 1'b1;
            end else if (int'(allocs) < NArrays) begin
                dec_index   = W'(allocs);
                allocs_next = allocs + 1'b1;
                dec_clear   = 1'b1;
            end else begin
                dec_error = 1'b1;
            end
        end else begin
            // A free always echoes the requested index, even when rejected
            dec_index = sel_array;
            if (int'(sel_array) >= int'(allocs)) begin
                dec_error = 1'b1;
            end else if (int'(freed_top) == NArrays) begin
                dec_error = 1'b1;
            end else begin
                dec_push       = 1'b1;
                freed_top_next = freed_top + 1'b1;
            end
        end
        use_next = W'(allocs_next - freed_top_next);
    end

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: allocations detour through CLEAR, everything else goes straight to RESP
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = dec_clear ? CLEAR : RESP;
            CLEAR:   if (k == KW'(NArea - 1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner and commit counter updates on the accept edge; step k while clearing
    always_ff @(posedge clock) begin
        if (reset) begin
            rr         <= '0;
            win        <= '0;
            cur_index  <= '0;
            cur_error  <= 1'b0;
            k          <= '0;
            allocs     <= '0;
            freed_top  <= '0;
            high_water <= '0;
        end else if (accept) begin
            win        <= pick;
            rr         <= (int'(pick) == NReq - 1) ? '0 : pick + 1'b1;
            cur_index  <= dec_index;
            cur_error  <= dec_error;
            k          <= '0;
            allocs     <= allocs_next;
            freed_top  <= freed_top_next;
            if (use_next > high_water) begin
                high_water <= use_next;
            end
        end else if (state == CLEAR) begin
            k <= k + 1'b1;
        end
    end

    // Freed-array stack storage
    always_ff @(posedge clock) begin
        // NOTE: the stack contents are not reset; freed_top alone says which entries are meaningful.
        if (!reset && accept && dec_push) begin
            freed[SW'(freed_top)] <= sel_array;
        end
    end

    assign in_use     = W'(allocs - freed_top);
    assign heap_wdata = '0;

    // Strobes and response fields decoded from the current state
    always_comb begin
        grant      = '0;
        resp_array = '0;
        resp_error = 1'b0;
        heap_we    = 1'b0;
        heap_addr  = '0;
        size_we    = 1'b0;
        size_array = '0;
        case (state)
            CLEAR: begin
                heap_we   = 1'b1;
                heap_addr = cur_index * W'(NArea) + W'(k);
                if (k == '0) begin
                    size_we    = 1'b1;
                    size_array = cur_index;
                end
            end
            RESP: begin
                grant[win] = 1'b1;
                resp_array = cur_index;
                resp_error = cur_error;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_heap_array_alloc_arbiter.sv
// tb_heap_array_alloc_arbiter
// Directed scenarios followed by randomized request batches, each
// transaction compared against a queue-based model of the allocator.

module tb_heap_array_alloc_arbiter;

    localparam int NREQ  = 4;
    localparam int NARR  = 16;
    localparam int NAREA = 4;
    localparam int W     = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_free;
    logic [NREQ*W-1:0] req_array;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      resp_array;
    logic              resp_error;
    logic              heap_we;
    logic [W-1:0]      heap_addr;
    logic [W-1:0]      heap_wdata;
    logic              size_we;
    logic [W-1:0]      size_array;
    logic [W-1:0]      in_use;
    logic [W-1:0]      high_water;

    heap_array_alloc_arbiter #(
        .NReq(NREQ), .NArrays(NARR), .NArea(NAREA), .MemoryElementWidth(W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
        .grant(grant), .resp_array(resp_array), .resp_error(resp_error),
        .heap_we(heap_we), .heap_addr(heap_addr), .heap_wdata(heap_wdata),
        .size_we(size_we), .size_array(size_array),
        .in_use(in_use), .high_water(high_water)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: freed stack as a queue, fresh-index counter, rr pointer
    logic [W-1:0] stack[$];
    int           m_allocs;
    int           m_rr;
    int           m_hw;

    // Last observed response, for directed spot checks
    logic [W-1:0]    last_resp;
    logic            last_err;
    logic [W-1:0]    last_use;
    logic [NREQ-1:0] gq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_reset();
        stack.delete();
        m_allocs = 0;
        m_rr     = 0;
        m_hw     = 0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int r, input logic fr, input int arr);
        req_valid[r]        = 1'b1;
        req_free[r]         = fr;
        req_array[r*W +: W] = W'(arr);
    endtask

    // Serve one transaction starting from an IDLE negedge with requests pending
    task automatic do_one();
        int           w;
        logic         is_free;
        logic [W-1:0] arr;
        logic [W-1:0] exp_idx;
        logic         exp_err;
        int           use_now;
        w = -1;
        check("idle_grant", grant, 0);
        check("idle_heap_we", heap_we, 0);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (m_rr + i) % NREQ;
            if (w < 0 && req_valid[j]) w = j;
        end
        m_rr    = (w + 1) % NREQ;
        is_free = req_free[w];
        arr     = req_array[w*W +: W];
        exp_idx = '0;
        exp_err = 1'b0;
        if (!is_free) begin
            if (stack.size() > 0) exp_idx = stack.pop_back();
            else if (m_allocs < NARR) begin
                exp_idx = W'(m_allocs);
                m_allocs++;
            end else exp_err = 1'b1;
        end else begin
            exp_idx = arr;
            if (int'(arr) >= m_allocs) exp_err = 1'b1;
            else if (stack.size() == NARR) exp_err = 1'b1;
            else stack.push_back(arr);
        end
        use_now = m_allocs - stack.size();
        if (use_now > m_hw) m_hw = use_now;
        tick();
        if (!is_free && !exp_err) begin
            for (int kk = 0; kk < NAREA; kk++) begin
                check("clr_we", heap_we, 1);
                check("clr_addr", heap_addr, (int'(exp_idx) * NAREA + kk) & 32'hFFF);
                check("clr_wdata", heap_wdata, 0);
                check("clr_size_we", size_we, (kk == 0) ? 1 : 0);
                if (kk == 0) check("clr_size_array", size_array, exp_idx);
                check("clr_grant", grant, 0);
                tick();
            end
        end
        check("grant", grant, 1 << w);
        check("resp_array", resp_array, exp_idx);
        check("resp_error", resp_error, exp_err);
        check("resp_heap_we", heap_we, 0);
        check("in_use", in_use, use_now);
        check("high_water", high_water, m_hw);
        last_resp = resp_array;
        last_err  = resp_error;
        last_use  = in_use;
        gq.push_back(grant);
        req_valid[w] = 1'b0;
        tick();
    endtask

    task automatic serve_all();
        for (int n = 0; n < 2 * NREQ && req_valid != '0; n++) do_one();
    endtask

    task automatic alloc_one(input int r);
        set_req(r, 1'b0, 0);
        serve_all();
    endtask

    task automatic free_one(input int r, input int arr);
        set_req(r, 1'b1, arr);
        serve_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = '0;
        req_free  = '0;
        req_array = '0;
        reset     = 1'b1;
        @(negedge clock);
        do_reset();

        // Reset state
        check("rst_grant", grant, 0);
        check("rst_resp_array", resp_array, 0);
        check("rst_resp_error", resp_error, 0);
        check("rst_heap_we", heap_we, 0);
        check("rst_heap_addr", heap_addr, 0);
        check("rst_size_we", size_we, 0);
        check("rst_size_array", size_array, 0);
        check("rst_in_use", in_use, 0);
        check("rst_high_water", high_water, 0);

        // 1: single alloc clears words 0..3 and returns index 0
        alloc_one(0);
        check("t1_resp", last_resp, 0);
        check("t1_in_use", last_use, 1);

        // 2: simultaneous requests are serviced round-robin
        do_reset();
        gq.delete();
        set_req(0, 1'b0, 0);
        set_req(2, 1'b0, 0);
        serve_all();
        check("t2_first", gq[0], 4'b0001);
        check("t2_second", gq[1], 4'b0100);
        gq.delete();
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        set_req(3, 1'b0, 0);
        serve_all();
        check("t2_order0", gq[0], 4'b1000);
        check("t2_order1", gq[1], 4'b0001);
        check("t2_order2", gq[2], 4'b0010);

        // 3: freed arrays are reused LIFO
        do_reset();
        alloc_one(0);
        alloc_one(0);
        alloc_one(0);
        check("t3_use_a", last_use, 3);
        free_one(1, 1);
        check("t3_use_b", last_use, 2);
        alloc_one(1);
        check("t3_lifo", last_resp, 1);
        check("t3_use_c", last_use, 3);
        alloc_one(2);
        check("t3_fresh", last_resp, 3);
        check("t3_use_d", last_use, 4);
        check("t3_hw", high_water, 4);

        // 4: exhaust the fresh indices, then one more alloc fails fast
        for (int i = 0; i < NARR - 4; i++) alloc_one(i % NREQ);
        check("t4_last_ok", last_resp, NARR - 1);
        alloc_one(3);
        check("t4_err", last_err, 1);
        check("t4_err_resp", last_resp, 0);

        // 5: free of a never-allocated index is rejected and echoed
        do_reset();
        alloc_one(0);
        alloc_one(1);
        free_one(2, 7);
        check("t5_err", last_err, 1);
        check("t5_echo", last_resp, 7);
        check("t5_use", last_use, 2);
        alloc_one(3);
        check("t5_next", last_resp, 2);

        // 6: reset in the middle of clearing abandons the request
        do_reset();
        set_req(0, 1'b0, 0);
        tick();
        tick();
        tick();
        check("t6_k2_we", heap_we, 1);
        check("t6_k2_addr", heap_addr, 2);
        reset     = 1'b1;
        req_valid = '0;
        tick();
        check("t6_rst_we", heap_we, 0);
        check("t6_rst_grant", grant, 0);
        reset = 1'b0;
        model_reset();
        tick();
        check("t6_idle_we", heap_we, 0);
        check("t6_idle_grant", grant, 0);
        check("t6_in_use", in_use, 0);
        alloc_one(0);
        check("t6_resp", last_resp, 0);

        // Randomized batches against the model
        do_reset();
        for (int b = 0; b < 40; b++) begin
            int mask;
            int cands[$];
            if (b == 20) do_reset();
            mask = $urandom_range(1, 15);
            cands.delete();
            for (int i = 0; i < m_allocs; i++) begin
                bit freed_already;
                freed_already = 1'b0;
                foreach (stack[s]) if (int'(stack[s]) == i) freed_already = 1'b1;
                if (!freed_already) cands.push_back(i);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (mask[r]) begin
                    if (cands.size() > 0 && $urandom_range(0, 2) == 0) begin
                        int j;
                        j = $urandom_range(0, cands.size() - 1);
                        set_req(r, 1'b1, cands[j]);
                        cands.delete(j);
                    end else if ($urandom_range(0, 7) == 0) begin
                        set_req(r, 1'b1, m_allocs + NREQ + $urandom_range(0, 20));
                    end else begin
                        set_req(r, 1'b0, 0);
                    end
                end
            end
            serve_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
